// File: rtl/axis_pkg.sv
// Shared AXI4-Stream types for the egress path: beat word, TX state enum, counter widths.
package axis_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned USER_W     = 128;
  localparam int unsigned PKT_CNT_W  = 32;
  localparam int unsigned BEAT_CNT_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tlast;
  } axis_word_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

endpackage

// File: rtl/axis_pkt_counter.sv
// Pending-packet up/down counter: saturates at max_cnt with a sticky overflow flag,
// and a decrement at zero holds zero.
module axis_pkt_counter #(
  parameter int unsigned max_cnt = 8,
  localparam int unsigned CNT_W  = $clog2(max_cnt + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cnt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (count == CNT_MAX) ovf <= 1'b1;
          else                  count <= count + CNT_W'(1);
        end
        2'b01: begin
          if (count != '0) count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_egress_tx.sv
// FIFO-to-AXIS transmitter with registered output stage and store-and-forward gating.
// Define AXIS_TX_CUT_THROUGH_EN to start transmitting as soon as the FIFO is non-empty.
module axis_egress_tx
  import axis_pkg::*;
#(
  parameter int unsigned data_width = 64,
  parameter int unsigned data_user  = 128,
  parameter int unsigned max_pkts   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic                    fifo_rd_en,
  input  axis_word_t              fifo_rd_data,
  input  logic                    fifo_empty,
  input  logic                    pkt_commit,
  output logic [data_width-1:0]   m_axis_tdata,
  output logic [data_width/8-1:0] m_axis_tkeep,
  output logic [data_user-1:0]    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [PKT_CNT_W-1:0]    pkts_sent,
  output logic [BEAT_CNT_W-1:0]   beat_cnt,
  output logic                    pend_ovf
);

  localparam int unsigned PEND_W = $clog2(max_pkts + 1);

  tx_state_e         state;
  axis_word_t        out_word;
  logic              can_pop;
  logic              pop_last;
  logic              hs;
  logic [PEND_W-1:0] pend;

`ifdef AXIS_TX_CUT_THROUGH_EN
  assign can_pop = 1'b1;
`else
  assign can_pop = (state == TX_SEND) || (pend != '0);
`endif

  assign fifo_rd_en = aresetn && can_pop && !fifo_empty && (!m_axis_tvalid || m_axis_tready);
  assign pop_last   = fifo_rd_en && fifo_rd_data.tlast;
  assign hs         = m_axis_tvalid && m_axis_tready;

  axis_pkt_counter #(
    .max_cnt (max_pkts)
  ) u_pend (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (pkt_commit),
    .dec     (pop_last),
    .count   (pend),
    .ovf     (pend_ovf)
  );

  // Output stage: a pop always refills the register, so back-to-back beats never bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_word      <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (fifo_rd_en) begin
      out_word      <= fifo_rd_data;
      m_axis_tvalid <= 1'b1;
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata = out_word.tdata;
  assign m_axis_tkeep = out_word.tkeep;
  assign m_axis_tuser = out_word.tuser;
  assign m_axis_tlast = out_word.tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= TX_IDLE;
      busy  <= 1'b0;
    end else if (fifo_rd_en) begin
      if (fifo_rd_data.tlast) begin
        state <= TX_IDLE;
        busy  <= 1'b0;
      end else begin
        state <= TX_SEND;
        busy  <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkts_sent <= '0;
      beat_cnt  <= '0;
    end else if (hs) begin
      if (m_axis_tlast) begin
        pkts_sent <= pkts_sent + PKT_CNT_W'(1);
        beat_cnt  <= '0;
      end else if (beat_cnt != '1) begin
        beat_cnt  <= beat_cnt + BEAT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_egress_tx.sv
// Self-checking bench for axis_egress_tx: queue FIFO model, in-order beat scoreboard.
module tb_axis_egress_tx;
  import axis_pkg::*;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  fifo_rd_en;
  axis_word_t            fifo_head = '0;
  logic                  fifo_empty = 1'b1;
  logic                  pkt_commit = 1'b0;
  logic [63:0]           m_axis_tdata;
  logic [7:0]            m_axis_tkeep;
  logic [127:0]          m_axis_tuser;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b0;
  logic                  busy;
  logic [31:0]           pkts_sent;
  logic [15:0]           beat_cnt;
  logic                  pend_ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  axis_word_t fifo_q[$];
  axis_word_t wr_q[$];
  axis_word_t exp_q[$];
  int hs_cyc[$];

  axis_egress_tx #(
    .data_width (64),
    .data_user  (128),
    .max_pkts   (8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_head),
    .fifo_empty    (fifo_empty),
    .pkt_commit    (pkt_commit),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .pkts_sent     (pkts_sent),
    .beat_cnt      (beat_cnt),
    .pend_ovf      (pend_ovf)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Fall-through FIFO model: writes become visible after the clock edge they are taken on.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_head  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      fifo_head  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard: every handshake must deliver the next word written, unchanged and in order.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      axis_word_t obs;
      obs = '{tdata: m_axis_tdata, tkeep: m_axis_tkeep, tuser: m_axis_tuser, tlast: m_axis_tlast};
      hs_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got tdata=%h tlast=%b, required no beat", obs.tdata, obs.tlast);
      end else begin
        if (obs !== exp_q[0]) begin
          errors++;
          $display("FAIL beat_data: got tdata=%h tkeep=%h tlast=%b, required tdata=%h tkeep=%h tlast=%b",
                   obs.tdata, obs.tkeep, obs.tlast, exp_q[0].tdata, exp_q[0].tkeep, exp_q[0].tlast);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d, input logic last, input logic commit);
    axis_word_t w;
    w.tdata = d;
    w.tkeep = 8'($urandom);
    w.tuser = {$urandom, $urandom, $urandom, $urandom};
    w.tlast = last;
    wr_q.push_back(w);
    exp_q.push_back(w);
    pkt_commit = commit;
    step();
    pkt_commit = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    pkt_commit = 1'b0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    repeat (3) step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_axis_tvalid) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) step();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser, busy, pkts_sent, beat_cnt, pend_ovf, fifo_rd_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h busy=%b pkts=%0d beats=%0d ovf=%b rd_en=%b, required all 0",
               m_axis_tvalid, m_axis_tdata, busy, pkts_sent, beat_cnt, pend_ovf, fifo_rd_en);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if (dut.u_pend.count !== 4'd0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got pend=%0d tvalid=%b, required pend=0 tvalid=0", dut.u_pend.count, m_axis_tvalid);
    end
  endtask

  task automatic test_single_packet();
    logic [63:0] seq [3];
    seq[0] = 64'h11; seq[1] = 64'h22; seq[2] = 64'h33;
    m_axis_tready = 1'b1;
    push_beat(seq[0], 1'b0, 1'b0);
    push_beat(seq[1], 1'b0, 1'b0);
    push_beat(seq[2], 1'b1, 1'b1);
    checks++;
    if (dut.u_pend.count !== 4'd1 || fifo_rd_en !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_commit_plus1: got pend=%0d rd_en=%b tvalid=%b, required 1 1 0", dut.u_pend.count, fifo_rd_en, m_axis_tvalid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== seq[i]) begin
        errors++;
        $display("FAIL single_beat%0d: got tvalid=%b tdata=%h, required 1 %h", i, m_axis_tvalid, m_axis_tdata, seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy: got %b, required 1", busy);
        end
      end
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || pkts_sent !== 32'd1 || beat_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got tvalid=%b pkts=%0d beats=%0d busy=%b, required 0 1 0 0", m_axis_tvalid, pkts_sent, beat_cnt, busy);
    end
  endtask

  task automatic test_sf_gating();
    int early;
    early = 0;
    m_axis_tready = 1'b1;
    push_beat(64'($urandom), 1'b0, 1'b0);
    push_beat(64'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_axis_tvalid !== 1'b0 || fifo_rd_en !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL sf_gating: got %0d cycles with output activity, required 0", early);
    end
    push_beat(64'($urandom), 1'b1, 1'b1);
    wait_drain("sf");
    checks++;
    if (pkts_sent !== 32'd2) begin
      errors++;
      $display("FAIL sf_pkts: got %0d, required 2", pkts_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int bad;
    bad = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) push_beat(64'($urandom), 1'(i == 4), 1'(i == 4));
    step();
    step();
    m_axis_tready = 1'b0;
    held = m_axis_tdata;
    for (int i = 0; i < 5; i++) begin
      step();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || fifo_rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, required 0", bad);
    end
    m_axis_tready = 1'b1;
    wait_drain("bp");
    checks++;
    if (pkts_sent !== 32'd3 || beat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL bp_stats: got pkts=%0d beats=%0d, required 3 0", pkts_sent, beat_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = pkts_sent;
    m_axis_tready = 1'b0;
    push_beat(64'($urandom), 1'b1, 1'b1);
    push_beat(64'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push_beat(64'($urandom), 1'(i == 3), 1'(i == 3));
    repeat (3) step();
    hs_cyc.delete();
    m_axis_tready = 1'b1;
    wait_drain("b2b");
    checks++;
    if (hs_cyc.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, required 6", hs_cyc.size());
    end else begin
      checks++;
      if (hs_cyc[5] - hs_cyc[0] != 5) begin
        errors++;
        $display("FAIL b2b_consecutive: got span %0d cycles, required 5", hs_cyc[5] - hs_cyc[0]);
      end
    end
    checks++;
    if (pkts_sent - base !== 32'd3) begin
      errors++;
      $display("FAIL b2b_pkts: got %0d, required 3", pkts_sent - base);
    end
  endtask

  task automatic test_overflow();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pkt_commit = 1'b1;
      step();
    end
    pkt_commit = 1'b0;
    checks++;
    if (dut.u_pend.count !== 4'd8 || pend_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_max: got pend=%0d ovf=%b, required 8 0", dut.u_pend.count, pend_ovf);
    end
    pkt_commit = 1'b1;
    step();
    pkt_commit = 1'b0;
    checks++;
    if (dut.u_pend.count !== 4'd8 || pend_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got pend=%0d ovf=%b, required 8 1", dut.u_pend.count, pend_ovf);
    end
    m_axis_tready = 1'b1;
    push_beat(64'($urandom), 1'b1, 1'b0);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL simul_pop: got rd_en=%b, required 1", fifo_rd_en);
    end
    pkt_commit = 1'b1;
    step();
    pkt_commit = 1'b0;
    checks++;
    if (dut.u_pend.count !== 4'd8 || pend_ovf !== 1'b1) begin
      errors++;
      $display("FAIL simul_pend: got pend=%0d ovf=%b, required 8 1", dut.u_pend.count, pend_ovf);
    end
    wait_drain("ovf");
    do_reset();
  endtask

  task automatic test_reset_mid_packet();
    logic [63:0] d [4];
    int n;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d[i] = {32'($urandom), 32'(i)};
      push_beat(d[i], 1'(i == 3), 1'(i == 3));
    end
    n = 0;
    while (!(m_axis_tvalid && m_axis_tdata == d[1]) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!(m_axis_tvalid && m_axis_tdata == d[1])) begin
      errors++;
      $display("FAIL rst_mid_reach: got tdata=%h, required %h", m_axis_tdata, d[1]);
    end
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser, busy, pkts_sent, beat_cnt, fifo_rd_en} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got tvalid=%b tdata=%h busy=%b pkts=%0d beats=%0d rd_en=%b, required all 0",
               m_axis_tvalid, m_axis_tdata, busy, pkts_sent, beat_cnt, fifo_rd_en);
    end
    repeat (2) step();
    aresetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || dut.u_pend.count !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_idle: got busy=%b tvalid=%b pend=%0d, required 0 0 0", busy, m_axis_tvalid, dut.u_pend.count);
    end
    m_axis_tready = 1'b1;
    push_beat(64'($urandom), 1'b0, 1'b0);
    push_beat(64'($urandom), 1'b1, 1'b1);
    wait_drain("rst_mid");
    checks++;
    if (pkts_sent !== 32'd1 || beat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_after: got pkts=%0d beats=%0d, required 1 0", pkts_sent, beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_sf_gating();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
